hw2_down_timer: RTL and testbench

HW2_DOWN_TIMER -- requirements
Module: hw2_down_timer

---
 rtl/hw2_down_timer.sv | 46 ++++
 tb/tb_hw2_down_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hw2_down_timer.sv
// hw2_down_timer: presettable down counter with one-shot/auto-reload modes and cascadable borrow
module hw2_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             SR,
  input  logic [WIDTH-1:0] P,
  input  logic             PE,
  input  logic             CEP,
  input  logic             CET,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t           state;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             step;
  assign zero = (Q == '0);
  assign step = (state == RUN) && CEP && CET;
  assign BUSY = (state == RUN);
  // borrow ignores CEP so a cascaded upper stage sees it whenever the lower stage is enabled
  assign TC   = CET && zero && (state == RUN);
  always_ff @(posedge CP or negedge SR) begin
    if (!SR) begin
      Q     <= '0;
      r     <= '0;
      state <= IDLE;
      DONE  <= 1'b0;
    end else if (!PE) begin
      Q     <= P;
      r     <= P;
      state <= RUN;
      DONE  <= 1'b0;
    end else if (step) begin
      DONE  <= zero;
      Q     <= !zero ? Q - 1'b1 : (MODE ? r : Q);
      state <= (zero && !MODE) ? EXPIRED : RUN;
    end else begin
      DONE  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hw2_down_timer.sv
// tb_hw2_down_timer: directed and random checks of the down timer against a cycle model
module tb_hw2_down_timer;
  localparam int IDLE = 0, RUN = 1, EXP = 2;
  typedef struct {int q; int r; int st; bit d;} mdl_t;
  logic CP = 0, SR = 0, PE = 1, CEP = 0, CET = 0, MODE = 0;
  logic [7:0] P = 0;
  logic [7:0] Q;
  logic TC, BUSY, DONE;
  logic [3:0] cp_lo = 0, cp_hi = 0, cq_lo, cq_hi;
  logic ctc_lo, ctc_hi, cb_lo, cb_hi, cd_lo, cd_hi;
  int total = 0, bad = 0;
  mdl_t m, ml, mh;
  always #5 CP = ~CP;
  hw2_down_timer #(.WIDTH(8)) dut (.CP(CP), .SR(SR), .P(P), .PE(PE), .CEP(CEP), .CET(CET), .MODE(MODE),
    .Q(Q), .TC(TC), .BUSY(BUSY), .DONE(DONE));
  hw2_down_timer #(.WIDTH(4)) u_lo (.CP(CP), .SR(SR), .P(cp_lo), .PE(PE), .CEP(CEP), .CET(CET), .MODE(1'b1),
    .Q(cq_lo), .TC(ctc_lo), .BUSY(cb_lo), .DONE(cd_lo));
  hw2_down_timer #(.WIDTH(4)) u_hi (.CP(CP), .SR(SR), .P(cp_hi), .PE(PE), .CEP(CEP), .CET(ctc_lo), .MODE(1'b1),
    .Q(cq_hi), .TC(ctc_hi), .BUSY(cb_hi), .DONE(cd_hi));

  function automatic mdl_t nxt(mdl_t s, bit pe, int p, bit cep, bit cet, bit mode);
    if (!pe) begin
      s.q = p; s.r = p; s.st = RUN; s.d = 0;
    end else if (s.st == RUN && cep && cet) begin
      s.d = (s.q == 0);
      if (s.q != 0) s.q = s.q - 1;
      else if (mode) s.q = s.r;
      else s.st = EXP;
    end else s.d = 0;
    return s;
  endfunction

  function automatic int tcm(mdl_t s, bit cet);
    return (cet && s.q == 0 && s.st == RUN) ? 1 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{0, 0, IDLE, 0}; ml = m; mh = m;
  endtask

  task automatic check_all();
    chk("q", Q, m.q);
    chk("tc", TC, tcm(m, CET));
    chk("busy", BUSY, m.st == RUN);
    chk("done", DONE, m.d);
    chk("lo_q", cq_lo, ml.q);
    chk("hi_q", cq_hi, mh.q);
    chk("lo_tc", ctc_lo, tcm(ml, CET));
    chk("hi_tc", ctc_hi, tcm(mh, bit'(tcm(ml, CET))));
    chk("lo_done", cd_lo, ml.d);
    chk("hi_done", cd_hi, mh.d);
  endtask

  task automatic cyc();
    bit lo_tc;
    @(posedge CP);
    lo_tc = bit'(tcm(ml, CET));
    m  = nxt(m, PE, P, CEP, CET, MODE);
    ml = nxt(ml, PE, cp_lo, CEP, CET, 1'b1);
    mh = nxt(mh, PE, cp_hi, CEP, lo_tc, 1'b1);
    #1;
    check_all();
  endtask

  task automatic load(int v, bit mode);
    P = v[7:0]; MODE = mode; PE = 0;
    cyc();
    PE = 1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_q", Q, 0); chk("rst_busy", BUSY, 0); chk("rst_tc", TC, 0); chk("rst_done", DONE, 0);
    SR = 1; CEP = 1; CET = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("noload_q", Q, 0); chk("noload_busy", BUSY, 0); chk("noload_done", DONE, 0);
    end
    load(3, 0);
    chk("os_q0", Q, 3);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("os_q", Q, k < 4 ? 3 - k : 0);
      chk("os_done", DONE, k == 4);
    end
    chk("os_busy", BUSY, 0); chk("os_tc", TC, 0);
    cyc();
    chk("os_done_clr", DONE, 0);
    load(2, 1);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("ar_q", Q, ((2 - k) % 3 + 3) % 3);
      chk("ar_done", DONE, k % 3 == 0);
      chk("ar_busy", BUSY, 1);
    end
    load(5, 0);
    cyc(); cyc();
    chk("hold_q3", Q, 3);
    CEP = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold_q", Q, 3); chk("hold_done", DONE, 0);
    end
    CEP = 1;
    cyc(); cyc(); cyc();
    chk("tc_on", TC, 1);
    CET = 0; #1;
    chk("tc_cet_off", TC, 0);
    cyc();
    chk("tc_cet_off2", TC, 0); chk("cet_hold_q", Q, 0);
    CET = 1;
    load(6, 1);
    cyc(); cyc();
    chk("pre_q4", Q, 4);
    load(9, 1);
    chk("loadwin_q", Q, 9);
    cyc();
    chk("loadwin_q8", Q, 8);
    @(negedge CP); SR = 0; #1;
    model_reset();
    chk("arst_q", Q, 0); chk("arst_busy", BUSY, 0); chk("arst_tc", TC, 0); chk("arst_done", DONE, 0);
    check_all();
    #2 SR = 1;
    for (int i = 0; i < 3; i++) cyc();
    chk("post_rst_q", Q, 0);
    @(negedge CP); SR = 0; PE = 0; P = 7; #1;
    model_reset();
    #3 SR = 1;
    cyc();
    PE = 1;
    chk("rel_load_q", Q, 7); chk("rel_load_busy", BUSY, 1);
    load(0, 1);
    chk("p0_tc", TC, 1);
    cyc();
    chk("p0_done", DONE, 1);
    cyc();
    chk("r0_done", DONE, 1);
    cp_lo = 4'h0; cp_hi = 4'h1;
    load(0, 0);
    chk("casc_load", {cq_hi, cq_lo}, 8'h10);
    cyc();
    chk("casc_hi_dec", cq_hi, 0);
    for (int i = 0; i < 6; i++) cyc();
    cp_lo = 4'h2; cp_hi = 4'h2;
    load(0, 0);
    for (int i = 0; i < 12; i++) cyc();
    for (int i = 0; i < 400; i++) begin
      PE = ($urandom_range(0, 11) != 0);
      P = 8'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 12));
      CEP = ($urandom_range(0, 3) != 0);
      CET = ($urandom_range(0, 4) != 0);
      MODE = 1'($urandom_range(0, 1));
      cp_lo = 4'($urandom); cp_hi = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        @(negedge CP); SR = 0; #1;
        model_reset();
        check_all();
        #2 SR = 1;
      end
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
